ti_q294_iter_layer: RTL and testbench

- Parametrised, sequential successor to the single-nibble quadratic component function.
- Applies the Midori64 quadratic S-box factor Q294 to NIBBLES nibbles in 3-share threshold form, 1 to 4 times per transaction (mode-selected).
- Registers the shares between successive applications and uses a valid/ready handshake on both sides.
- Sits in the Midori64 TI datapath between the state register and the affine S-box layers; also usable standalone for Q^n evaluation.

---
 rtl/ti_midori_pkg.sv | 39 +++
 rtl/ti_q294_share_fn.sv | 22 ++
 rtl/ti_q294_iter_layer.sv | 92 +++++++++
 tb/tb_ti_q294_iter_layer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ti_midori_pkg.sv
// Shared constants, state encoding and share-slice helpers
// for the Midori64 threshold-implementation datapath.
package ti_midori_pkg;

    localparam int SHARES   = 3;
    localparam int NIBBLE_W = 4;
    localparam int MODE_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Low bit of share s inside a packed share vector.
    function automatic int share_lo(
        input int s,
        input int nibbles
    );
        return s * NIBBLE_W * nibbles;
    endfunction

    // Low bit of nibble k of share s.
    function automatic int nib_lo(
        input int s,
        input int k,
        input int nibbles
    );
        return share_lo(s, nibbles) + k * NIBBLE_W;
    endfunction

    // Cyclic neighbour share feeding the cross terms.
    function automatic int next_share(
        input int s
    );
        return (s + 1) % SHARES;
    endfunction

endpackage

// File: rtl/ti_q294_share_fn.sv
// One nibble of one output share of the shared Q294 factor.
// Uses only the own share x and its cyclic neighbour y.
module ti_q294_share_fn (
    input  logic [3:0] x_i,
    input  logic [3:1] y_i,
    output logic [3:0] o_o
);

    assign o_o[3] = x_i[3];
    assign o_o[2] = x_i[2];

    assign o_o[1] = x_i[1]
                  ^ (x_i[3] & x_i[2])
                  ^ (x_i[3] & y_i[2])
                  ^ (y_i[3] & x_i[2]);

    assign o_o[0] = x_i[0]
                  ^ (x_i[3] & x_i[1])
                  ^ (x_i[3] & y_i[1])
                  ^ (y_i[3] & x_i[1]);

endmodule

// File: rtl/ti_q294_iter_layer.sv
// Iterated 3-share Q294 layer: applies the shared factor
// 1..4 times per transaction behind valid/ready handshakes.
import ti_midori_pkg::*;

module ti_q294_iter_layer #(
    parameter int NIBBLES = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [MODE_W-1:0]                in_mode,
    input  logic [SHARES*NIBBLE_W*NIBBLES-1:0] in_shares,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SHARES*NIBBLE_W*NIBBLES-1:0] out_shares
);

    localparam int W = SHARES * NIBBLE_W * NIBBLES;

    state_e            st_q;
    logic [MODE_W-1:0] cnt_q;
    logic [W-1:0]      state_q;
    logic [W-1:0]      state_d;
    logic              out_valid_q;

    // Shared Q of the current state, one cell per share/nibble.
    for (genvar s = 0; s < SHARES; s++) begin : g_share
        for (genvar k = 0; k < NIBBLES; k++) begin : g_nib
            localparam int XL = nib_lo(s, k, NIBBLES);
            localparam int YL = nib_lo(next_share(s), k, NIBBLES);
            ti_q294_share_fn u_fn (
                .x_i (state_q[XL +: 4]),
                .y_i (state_q[YL + 1 +: 3]),
                .o_o (state_d[XL +: 4])
            );
        end
    end

    // Ready is high in IDLE, or in DONE when the result drains.
    assign in_ready = ~rst & ((st_q == IDLE) |
                              ((st_q == DONE) & out_ready));

    assign out_valid  = out_valid_q;
    assign out_shares = state_q;

    // Control FSM with the count and share state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= IDLE;
            cnt_q       <= '0;
            state_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (st_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= in_shares;
                        cnt_q   <= in_mode;
                        st_q    <= BUSY;
                    end
                end
                BUSY: begin
                    state_q <= state_d;
                    if (cnt_q == '0) begin
                        st_q        <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            state_q <= in_shares;
                            cnt_q   <= in_mode;
                            st_q    <= BUSY;
                        end else begin
                            st_q <= IDLE;
                        end
                    end
                end
                default: begin
                    st_q        <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ti_q294_iter_layer.sv
// Scoreboard bench for ti_q294_iter_layer: unshared
// reference model, latency, stall and reset checks.
module tb_ti_q294_iter_layer;

    localparam int N = 16;
    localparam int W = 3 * 4 * N;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_mode;
    logic [W-1:0] in_shares;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_shares;

    int checks;
    int failures;
    int cyc;
    int or_mode;
    bit b2b;

    typedef struct {
        logic [63:0] exp;
        int          acc;
        int          n;
        bit          same;
    } sb_t;

    sb_t sb[$];

    ti_q294_iter_layer #(.NIBBLES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_shares  (in_shares),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_shares (out_shares)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Unshared Q294 on a single nibble.
    function automatic logic [3:0] q1(input logic [3:0] a);
        logic [3:0] r;
        r[3] = a[3];
        r[2] = a[2];
        r[1] = a[1] ^ (a[3] & a[2]);
        r[0] = a[0] ^ (a[3] & a[1]);
        return r;
    endfunction

    function automatic logic [63:0] qvec(
        input logic [63:0] u,
        input int n
    );
        logic [63:0] r;
        logic [3:0]  v;
        for (int k = 0; k < N; k++) begin
            v = u[4*k +: 4];
            for (int j = 0; j < n; j++) v = q1(v);
            r[4*k +: 4] = v;
        end
        return r;
    endfunction

    function automatic logic [63:0] unshare(
        input logic [W-1:0] v
    );
        return v[63:0] ^ v[127:64] ^ v[191:128];
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [W-1:0] r192();
        return {r64(), r64(), r64()};
    endfunction

    function automatic logic [W-1:0] mk1(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic [3:0] c
    );
        logic [W-1:0] v;
        v = '0;
        v[3:0]     = a;
        v[67:64]   = b;
        v[131:128] = c;
        return v;
    endfunction

    task automatic chk(
        input string nm,
        input logic [W-1:0] act,
        input logic [W-1:0] req
    );
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h",
                     nm, act, req);
        end
    endtask

    task automatic send(
        input  logic [W-1:0] sh,
        input  logic [1:0]   m,
        input  bit           push,
        input  bit           same,
        output bit           bb
    );
        int t;
        t  = 0;
        bb = 1'b0;
        do begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_shares = sh;
            in_mode   = m;
            #4;
            t++;
        end while (!in_ready && t < 300);
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=0 required=1");
        end else begin
            bb = out_valid;
            if (push)
                sb.push_back('{qvec(unshare(sh), m + 1),
                               cyc + 1, m + 1, same});
        end
        @(posedge clk);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            in_valid  = 1'b0;
            in_mode   = 2'($urandom);
            in_shares = r192();
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        idle(1);
        while (sb.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0",
                     sb.size());
        end
        idle(2);
    endtask

    // Downstream ready: random, forced low or forced high.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (or_mode == 0) out_ready = ($urandom % 4) != 0;
            else              out_ready = (or_mode == 2);
        end
    end

    // Monitor: latency, stability, ready and value checks.
    initial begin
        bit           prev;
        logic [W-1:0] held;
        logic [63:0]  last_s0;
        sb_t          e;
        prev    = 1'b0;
        held    = '0;
        last_s0 = '0;
        forever begin
            @(negedge clk);
            #4;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%h required=none",
                             out_shares);
                end else begin
                    if (!prev) begin
                        held = out_shares;
                        chk("latency", W'(cyc),
                            W'(sb[0].acc + sb[0].n));
                    end else begin
                        chk("stall_stable", out_shares, held);
                    end
                    chk("in_ready_done", W'(in_ready),
                        W'(out_ready));
                    if (out_ready) begin
                        e = sb.pop_front();
                        chk("value", W'(unshare(out_shares)),
                            W'(e.exp));
                        if (e.same)
                            chk("noncomplete_s0",
                                W'(out_shares[63:0]), W'(last_s0));
                        last_s0 = out_shares[63:0];
                    end
                end
            end
            prev = out_valid;
        end
    end

    // Stimulus.
    initial begin
        logic [63:0]  s0, s1, u;
        logic [W-1:0] v;
        bit           bb;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        or_mode   = 0;
        b2b       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 2'd0;
        in_shares = '0;

        #3;
        chk("rst_in_ready", W'(in_ready), W'(0));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_shares", out_shares, W'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", W'(in_ready), W'(1));
        chk("post_rst_out_valid", W'(out_valid), W'(0));

        send(mk1(4'hE, 4'h0, 4'h0), 2'd0, 1, 0, bb);
        idle(1);
        for (int m = 1; m < 4; m++) begin
            send(mk1(4'h3, 4'h9, 4'h4), 2'(m), 1, 0, bb);
            idle(1);
        end

        for (int i = 0; i < 8; i++) begin
            s0 = r64();
            s1 = r64();
            send({r64(), s1, s0}, 2'd0, 1, 0, bb);
            send({r64(), s1, s0}, 2'd0, 1, 1, bb);
            idle($urandom % 2);
        end

        for (int i = 0; i < 200; i++) begin
            send(r192(), 2'($urandom), 1, 0, bb);
            if ($urandom % 3 == 0) idle($urandom % 3);
        end

        for (int i = 0; i < 1000; i++) begin
            send(r192(), 2'd3, 1, 0, bb);
            if ($urandom % 4 == 0) idle(1);
        end
        drain();

        or_mode = 1;
        send(r192(), 2'd0, 1, 0, bb);
        fork
            send(r192(), 2'($urandom), 1, 0, b2b);
            begin
                int t;
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!out_valid && t < 50);
                repeat (5) @(negedge clk);
                or_mode = 2;
            end
        join
        chk("no_bubble", W'(b2b), W'(1));
        drain();

        or_mode = 2;
        send(r192(), 2'd3, 0, 0, bb);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", W'(out_valid), W'(0));
        chk("abort_out_shares", out_shares, W'(0));
        chk("abort_in_ready", W'(in_ready), W'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_rel_in_ready", W'(in_ready), W'(1));
        idle(15);
        or_mode = 0;
        send(mk1(4'h3, 4'h9, 4'h4), 2'd1, 1, 0, bb);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
